// File: rtl/interrupt_controller.sv
// Edge-triggered 4-line interrupt controller with STATUS/CAUSE/EPC/PENDING registers.
// Define IRQ_SYNC_EN to insert a 2-flop synchronizer on every irq line before edge detection.
module interrupt_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  irq,
  input  logic [31:0] pc_in,
  input  logic        stall,
  input  logic        eret,
  input  logic        cp0_we,
  input  logic [1:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic        int_req,
  output logic [31:0] int_vector,
  output logic [31:0] epc_out
);

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  state_e      r_state, w_state_next;
  logic [1:0]  r_src, w_src_next, w_lowest;
  logic [3:0]  r_irq_prev, r_pending, w_pending_next;
  logic [3:0]  w_irq, w_rise, w_active, w_src_onehot, w_mask_new;
  logic [4:0]  r_status, w_status_next;
  logic [2:0]  r_cause, w_cause_next;
  logic [31:0] r_epc, w_epc_next;
  logic        w_accept, w_status_wr, w_withdraw;

`ifdef IRQ_SYNC_EN
  logic [3:0] r_sync1, r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq;
      r_sync2 <= r_sync1;
    end
  end

  assign w_irq = r_sync2;
`else
  assign w_irq = irq;
`endif

  assign w_rise       = w_irq & ~r_irq_prev;
  assign w_active     = r_pending & r_status[3:0];
  assign w_src_onehot = 4'b0001 << r_src;
  assign w_mask_new   = cp0_wdata[3:0];
  assign w_accept     = (r_state == StReq) && !stall;
  assign w_status_wr  = cp0_we && (cp0_addr == 2'd0);
  // A STATUS write that disables the latched source pulls back a stalled request.
  assign w_withdraw   = (r_state == StReq) && stall && w_status_wr &&
                        (!cp0_wdata[4] || !w_mask_new[r_src]);

  always_comb begin
    w_lowest = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_active[i]) w_lowest = 2'(i);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_src_next   = r_src;
    unique case (r_state)
      StIdle: begin
        if (r_status[4] && (w_active != 4'd0)) begin
          w_state_next = StReq;
          w_src_next   = w_lowest;
        end
      end
      StReq: begin
        if (w_accept)        w_state_next = StService;
        else if (w_withdraw) w_state_next = StIdle;
      end
      StService: begin
        if (eret) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    // A fresh edge on the source being cleared keeps its pending bit set.
    w_pending_next = (r_pending & ~(w_accept ? w_src_onehot : 4'd0)) | w_rise;

    w_status_next = r_status;
    if (w_status_wr) begin
      if (w_accept) w_status_next[3:0] = w_mask_new;
      else          w_status_next      = cp0_wdata[4:0];
    end
    if (w_accept) w_status_next[4] = 1'b0;
    if ((r_state == StService) && eret) w_status_next[4] = 1'b1;

    w_cause_next = r_cause;
    if (w_accept) w_cause_next = {1'b1, r_src};
    if ((r_state == StService) && eret) w_cause_next[2] = 1'b0;

    w_epc_next = r_epc;
    if (cp0_we && (cp0_addr == 2'd2)) w_epc_next = cp0_wdata;
    if (w_accept) w_epc_next = pc_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_src      <= '0;
      r_irq_prev <= '0;
      r_pending  <= '0;
      r_status   <= '0;
      r_cause    <= '0;
      r_epc      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_src      <= w_src_next;
      r_irq_prev <= w_irq;
      r_pending  <= w_pending_next;
      r_status   <= w_status_next;
      r_cause    <= w_cause_next;
      r_epc      <= w_epc_next;
    end
  end

  always_comb begin
    cp0_rdata = 32'd0;
    unique case (cp0_addr)
      2'd0:    cp0_rdata = {27'd0, r_status};
      2'd1:    cp0_rdata = {29'd0, r_cause};
      2'd2:    cp0_rdata = r_epc;
      2'd3:    cp0_rdata = {28'd0, r_pending};
      default: cp0_rdata = 32'd0;
    endcase
  end

  assign int_req    = (r_state == StReq);
  assign int_vector = 32'h80 + {26'd0, r_src, 4'd0};
  assign epc_out    = r_epc;

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: a behavioural model predicts every cycle's outputs,
// a negedge monitor compares them; directed scenarios add spec-constant checks.
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        rst, stall, eret, cp0_we, int_req;
  logic [3:0]  irq;
  logic [1:0]  cp0_addr;
  logic [31:0] pc_in, cp0_wdata, cp0_rdata, int_vector, epc_out;

  interrupt_controller dut (
    .clk        (clk),
    .rst        (rst),
    .irq        (irq),
    .pc_in      (pc_in),
    .stall      (stall),
    .eret       (eret),
    .cp0_we     (cp0_we),
    .cp0_addr   (cp0_addr),
    .cp0_wdata  (cp0_wdata),
    .cp0_rdata  (cp0_rdata),
    .int_req    (int_req),
    .int_vector (int_vector),
    .epc_out    (epc_out)
  );

  always #5 clk = ~clk;

`ifdef IRQ_SYNC_EN
  localparam int SyncDly = 2;
`else
  localparam int SyncDly = 0;
`endif

  // Reference model: request/handler flags plus architectural registers.
  logic        m_req, m_svc, m_ie, m_cv;
  logic [1:0]  m_src, m_cs;
  logic [3:0]  m_mask, m_pend, m_hist, m_s1, m_s2;
  logic [31:0] m_epc;

  typedef struct packed {
    logic        ireq;
    logic [31:0] vec;
    logic [31:0] epc;
    logic [31:0] rdata;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  logic [3:0] lvl = 4'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_req = 0; m_svc = 0; m_ie = 0; m_cv = 0; m_src = 0; m_cs = 0;
    m_mask = 0; m_pend = 0; m_hist = 0; m_s1 = 0; m_s2 = 0; m_epc = 0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_update();
    logic [3:0] w, rise, np, act;
    logic       acc, swr, was_svc;
    int         lo;
    if (rst) begin
      model_reset();
      return;
    end
`ifdef IRQ_SYNC_EN
    w = m_s2; m_s2 = m_s1; m_s1 = irq;
`else
    w = irq;
`endif
    rise    = w & ~m_hist;
    m_hist  = w;
    was_svc = m_svc;
    acc     = m_req && !stall;
    swr     = cp0_we && (cp0_addr == 2'd0);
    act     = m_pend & m_mask;
    np      = m_pend;
    if (acc) np[m_src] = 1'b0;
    np = np | rise;
    if (cp0_we && (cp0_addr == 2'd2)) m_epc = cp0_wdata;
    if (acc) begin
      m_epc = pc_in; m_cv = 1'b1; m_cs = m_src;
    end
    if (was_svc && eret) m_cv = 1'b0;
    if (!m_req && !m_svc) begin
      if (m_ie && (act != 4'd0)) begin
        lo = 3;
        for (int k = 3; k >= 0; k--) if (act[k]) lo = k;
        m_src = 2'(lo);
        m_req = 1'b1;
      end
    end else if (m_req) begin
      if (acc) begin
        m_req = 1'b0; m_svc = 1'b1;
      end else if (swr && (!cp0_wdata[4] || !cp0_wdata[m_src])) begin
        m_req = 1'b0;
      end
    end else if (eret) begin
      m_svc = 1'b0;
    end
    if (swr) begin
      m_mask = cp0_wdata[3:0];
      if (!acc) m_ie = cp0_wdata[4];
    end
    if (acc) m_ie = 1'b0;
    if (was_svc && eret) m_ie = 1'b1;
    m_pend = np;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.ireq = m_req;
    e.vec  = 32'h80 + 32'(m_src) * 16;
    e.epc  = m_epc;
    case (cp0_addr)
      2'd0:    e.rdata = {27'd0, m_ie, m_mask};
      2'd1:    e.rdata = {29'd0, m_cv, m_cs};
      2'd2:    e.rdata = m_epc;
      default: e.rdata = {28'd0, m_pend};
    endcase
    return e;
  endfunction

  // One clock: commit the previous cycle into the model, drive new inputs, queue the prediction.
  task automatic cycle(input logic r, input logic [3:0] i, input logic [31:0] pc, input logic st,
                       input logic er, input logic we, input logic [1:0] a, input logic [31:0] wd);
    model_update();
    @(posedge clk);
    #1;
    rst = r; irq = i; pc_in = pc; stall = st; eret = er;
    cp0_we = we; cp0_addr = a; cp0_wdata = wd;
    if (r) model_reset();
    q.push_back(model_out());
    #2;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("mon_int_req", {31'd0, int_req}, {31'd0, e.ireq});
      check("mon_int_vector", int_vector, e.vec);
      check("mon_epc_out", epc_out, e.epc);
      check("mon_cp0_rdata", cp0_rdata, e.rdata);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic got, bad;
    rst = 1; irq = 0; pc_in = 0; stall = 0; eret = 0; cp0_we = 0; cp0_addr = 0; cp0_wdata = 0;
    model_reset();

    cycle(1, 0, 0, 0, 0, 0, 2'd2, 0);
    cycle(1, 0, 0, 0, 0, 0, 2'd2, 0);
    check("rst_int_req", {31'd0, int_req}, 0);
    check("rst_vector", int_vector, 32'h80);
    check("rst_epc", epc_out, 0);

    // Single source, latency and capture.
    cycle(0, 0, 0, 0, 0, 1, 2'd0, 32'h1F);
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 2'd0, 0);
    cycle(0, 4'b0100, 32'h400, 0, 0, 0, 2'd0, 0);
    check("lat_n", {31'd0, int_req}, 0);
    cycle(0, 0, 32'h400, 0, 0, 0, 2'd0, 0);
    check("lat_n1", {31'd0, int_req}, 0);
    repeat (SyncDly) cycle(0, 0, 32'h400, 0, 0, 0, 2'd0, 0);
    cycle(0, 0, 32'h400, 0, 0, 0, 2'd0, 0);
    check("lat_n2_req", {31'd0, int_req}, 1);
    check("vec_a0", int_vector, 32'hA0);
    cycle(0, 0, 0, 0, 0, 0, 2'd1, 0);
    check("accept_drop", {31'd0, int_req}, 0);
    check("cause_6", cp0_rdata, 32'h6);
    check("epc_400", epc_out, 32'h400);
    cycle(0, 0, 0, 0, 0, 0, 2'd0, 0);
    check("ie_cleared", cp0_rdata, 32'h0F);
    cycle(0, 0, 0, 0, 1, 0, 2'd0, 0);
    cycle(0, 0, 0, 0, 0, 0, 2'd0, 0);
    check("ie_restored", cp0_rdata, 32'h1F);

    // Simultaneous edges: lowest index first, STATUS write during acceptance.
    cycle(0, 4'b1010, 0, 0, 0, 0, 2'd0, 0);
    cycle(0, 4'b1010, 0, 0, 0, 0, 2'd0, 0);
    repeat (SyncDly) cycle(0, 4'b1010, 0, 0, 0, 0, 2'd0, 0);
    cycle(0, 4'b1010, 32'h500, 0, 0, 1, 2'd0, 32'h1F);
    check("prio_req", {31'd0, int_req}, 1);
    check("vec_90", int_vector, 32'h90);
    cycle(0, 4'b1010, 0, 0, 0, 0, 2'd0, 0);
    check("accept_status_wr", cp0_rdata, 32'h0F);
    cycle(0, 4'b1010, 0, 0, 1, 0, 2'd0, 0);
    got = 0;
    for (int k = 0; k < 6 && !got; k++) begin
      cycle(0, 4'b1010, 0, 0, 0, 0, 2'd0, 0);
      if (int_req) got = 1;
    end
    check("second_req_seen", {31'd0, got}, 1);
    check("vec_b0", int_vector, 32'hB0);
    cycle(0, 4'b1010, 0, 0, 1, 0, 2'd0, 0);
    cycle(0, 0, 0, 0, 0, 0, 2'd0, 0);

    // Stall holds request; EPC write in acceptance loses to capture.
    cycle(0, 4'b0001, 0, 1, 0, 0, 2'd0, 0);
    cycle(0, 0, 0, 1, 0, 0, 2'd0, 0);
    repeat (SyncDly) cycle(0, 0, 0, 1, 0, 0, 2'd0, 0);
    cycle(0, 0, 32'h111, 1, 0, 0, 2'd0, 0);
    check("stall1_req", {31'd0, int_req}, 1);
    check("stall1_vec", int_vector, 32'h80);
    cycle(0, 0, 32'h222, 1, 0, 0, 2'd0, 0);
    check("stall2_req", {31'd0, int_req}, 1);
    cycle(0, 0, 32'h333, 1, 0, 0, 2'd0, 0);
    check("stall3_vec", int_vector, 32'h80);
    cycle(0, 0, 32'h1234, 0, 0, 1, 2'd2, 32'hDEAD);
    cycle(0, 0, 0, 0, 0, 0, 2'd2, 0);
    check("stall_epc", epc_out, 32'h1234);
    cycle(0, 0, 0, 0, 1, 0, 2'd0, 0);

    // Withdraw by masking, then re-enable.
    cycle(0, 4'b0010, 0, 1, 0, 0, 2'd0, 0);
    cycle(0, 0, 0, 1, 0, 0, 2'd0, 0);
    repeat (SyncDly) cycle(0, 0, 0, 1, 0, 0, 2'd0, 0);
    cycle(0, 0, 0, 1, 0, 1, 2'd0, 32'h0F);
    check("wd_req_before", {31'd0, int_req}, 1);
    cycle(0, 0, 0, 1, 0, 0, 2'd3, 0);
    check("wd_req_dropped", {31'd0, int_req}, 0);
    check("wd_pending", cp0_rdata, 32'h2);
    cycle(0, 0, 0, 0, 0, 1, 2'd0, 32'h1F);
    got = 0;
    for (int k = 0; k < 6 && !got; k++) begin
      cycle(0, 0, 0, 0, 0, 0, 2'd0, 0);
      if (int_req) got = 1;
    end
    check("wd_req_back", {31'd0, got}, 1);
    cycle(0, 0, 0, 0, 1, 0, 2'd0, 0);

    // Reset during service, irq held high afterwards.
    cycle(0, 4'b0100, 0, 0, 0, 0, 2'd0, 0);
    cycle(0, 4'b0100, 0, 0, 0, 0, 2'd0, 0);
    repeat (SyncDly) cycle(0, 4'b0100, 0, 0, 0, 0, 2'd0, 0);
    cycle(0, 4'b0100, 32'h777, 0, 0, 0, 2'd0, 0);
    cycle(0, 4'b0100, 0, 0, 0, 0, 2'd2, 0);
    cycle(1, 4'b0100, 0, 0, 0, 0, 2'd2, 0);
    check("svc_rst_req", {31'd0, int_req}, 0);
    check("svc_rst_vec", int_vector, 32'h80);
    check("svc_rst_epc", epc_out, 0);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      cycle(0, 4'b0100, 0, 0, 0, 0, 2'd0, 0);
      if (int_req !== 1'b0) bad = 1;
    end
    check("post_rst_no_req", {31'd0, bad}, 0);

    // Randomized traffic against the model.
    lvl = 4'b0100;
    for (int n = 0; n < 2500; n++) begin
      logic       r, st, er, we;
      logic [1:0] a;
      logic [31:0] wd;
      r   = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) lvl = lvl ^ 4'($urandom);
      st  = ($urandom_range(0, 2) == 0);
      er  = ($urandom_range(0, 5) == 0);
      we  = ($urandom_range(0, 7) == 0);
      a   = 2'($urandom);
      wd  = $urandom;
      if ((a == 2'd0) && ($urandom_range(0, 3) != 0)) wd[4] = 1'b1;
      cycle(r, lvl, $urandom, st, er, we, a, wd);
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 clk  input  1  single rising-edge clock for all state.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 irq  input  4  external interrupt lines; a rising edge requests service.
REQ-004 pc_in  input  32  resume PC offered by the pipeline, i.e. the PC the PC-select mux would have chosen.
REQ-005 stall  input  1  pipeline cannot redirect this cycle; blocks acceptance.
REQ-006 eret  input  1  return-from-exception strobe, 1 cycle.
REQ-007 cp0_we  input  1  register write strobe.
REQ-008 cp0_addr  input  2  register select: 0 STATUS, 1 CAUSE, 2 EPC, 3 PENDING.
REQ-009 cp0_wdata  input  32  write data.
REQ-010 cp0_rdata  output  32  combinational read of the register selected by cp0_addr; unused bits are 0.
REQ-011 int_req  output  1  INT to the PC-select mux: redirect fetch to int_vector.
REQ-012 int_vector  output  32  handler address.
REQ-013 epc_out  output  32  saved resume PC; the PC source on eret.

Function
REQ-014 The block SHALL register irq each cycle and set pending[i] on irq[i] 0->1 (previous value 0, current value 1); levels and falling edges are ignored.
REQ-015 The block SHALL implement STATUS as 5 bits: [3:0] mask, [4] IE.
REQ-016 The block SHALL implement CAUSE as 3 bits: [1:0] source, [2] valid.
REQ-017 The FSM SHALL have three states: IDLE, REQ and SERVICE.
REQ-018 In IDLE: if IE=1 and (pending & mask)!=0, the block SHALL latch src as the lowest set index and enter REQ on the next cycle.
REQ-019 In REQ: int_req SHALL be 1 and int_vector SHALL be 32'h80 + 16*src, with both held stable while stall=1.
REQ-020 In REQ with stall=0 (acceptance): EPC<=pc_in, CAUSE<={1,src}, pending[src]<=0, IE<=0, next state SERVICE, and int_req SHALL be 0 in the following cycle.
REQ-021 In SERVICE: int_req SHALL be 0; eret SHALL set IE<=1, CAUSE.valid<=0, and return the FSM to IDLE.
REQ-022 eret in IDLE or REQ SHALL be ignored.
REQ-023 A new edge on pending[src] in the acceptance cycle SHALL leave pending[src]=1 (set wins over clear).
REQ-024 A STATUS write that clears IE, or masks src, while in REQ with no acceptance in that cycle SHALL withdraw the request: return to IDLE, int_req=0 next cycle, pending unchanged.
REQ-025 A STATUS write in the acceptance cycle SHALL update mask only; IE SHALL still become 0.
REQ-026 Writes SHALL behave as follows: EPC (addr 2) writable in any state; CAUSE and PENDING writes ignored; an EPC write in the acceptance cycle SHALL lose to the capture.
REQ-027 Latency SHALL be: irq edge at cycle N -> pending at N+1 -> REQ (int_req=1) at N+2, with stall=0 and the source enabled.

Reset
REQ-028 While rst=1 the block SHALL force: state IDLE, pending=0, edge history=0, STATUS=0, CAUSE=0, EPC=0, int_req=0, int_vector=32'h80.
REQ-029 rst asserted in REQ or SERVICE SHALL abandon the interrupt immediately with no EPC capture, and the first post-reset edge SHALL be required for any new request.

Configuration
REQ-030 With IRQ_SYNC_EN defined, each irq line SHALL pass a 2-flop synchronizer before edge detection (reset to 0), adding 2 cycles to REQ-027 latency (int_req at N+4).
REQ-031 Without IRQ_SYNC_EN, irq SHALL be treated as synchronous to clk and the latency SHALL be as in REQ-027.

Verification
REQ-032 STATUS=0x1F, pulse irq=4'b0100 at cycle 10, pc_in=0x400 -> int_req=1 at cycle 12, int_vector=0xA0; at acceptance EPC=0x400, CAUSE=0x6, IE=0.
REQ-033 irq[3] and irq[1] rise together, STATUS=0x1F -> src=1 serviced first; after eret, src=3 requested with int_vector=0xB0.
REQ-034 REQ with stall=1 for 3 cycles and pc_in changing -> int_req and int_vector stable; EPC = pc_in of the first stall=0 cycle.
REQ-035 In REQ, write STATUS=0x0F -> int_req drops next cycle and PENDING still shows the bit; write 0x1F -> request reappears.
REQ-036 rst pulsed in SERVICE -> all outputs at reset values; irq held high after reset raises no request until it toggles 0->1.
